// File: rtl/rvx_tightly_coupled_memory.sv
// Dual-port word-organised SRAM responder for the RVX ibus (fetch, read-only) and
// dbus (load / byte-strobed store), with a fixed number of wait states per port.
module rvx_tightly_coupled_memory #(
   parameter int unsigned MEMORY_SIZE      = 8192,
   parameter int unsigned IBUS_WAIT_STATES = 0,
   parameter int unsigned DBUS_WAIT_STATES = 0
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [31:0] ibus_address,
   input  logic        ibus_rrequest,
   output logic [31:0] ibus_rdata,
   output logic        ibus_rresponse,
   input  logic [31:0] dbus_address,
   input  logic        dbus_rrequest,
   input  logic        dbus_wrequest,
   input  logic [31:0] dbus_wdata,
   input  logic [3:0]  dbus_wstrobe,
   output logic [31:0] dbus_rdata,
   output logic        dbus_rresponse,
   output logic        dbus_wresponse
);
   localparam int unsigned AW    = $clog2(MEMORY_SIZE);
   localparam int unsigned WORDS = MEMORY_SIZE / 4;
   localparam int unsigned IW    = (AW > 2) ? AW - 2 : 1;
   localparam int unsigned CW    = 4;

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

   logic [31:0] mem_q [WORDS];

   // ---------------- instruction port ----------------
   state_e          i_state_q, i_state_d;
   logic [CW-1:0]   i_cnt_q, i_cnt_d;
   logic [31:0]     i_addr_q, i_addr_c;
   logic            i_accept, i_commit, i_hit;
   logic [IW-1:0]   i_idx;
   logic [31:0]     i_rdata_q;
   logic            i_resp_q;

   // WAIT is held WAIT_STATES+1 cycles so the response lands 1+WAIT_STATES edges after acceptance
   always_comb begin
      i_state_d = i_state_q;
      i_cnt_d   = i_cnt_q;
      i_accept  = 1'b0;
      i_commit  = 1'b0;
      case (i_state_q)
         ST_IDLE, ST_RESP: begin
            i_state_d = ST_IDLE;
            if (ibus_rrequest && reset_n) begin
               i_accept = 1'b1;
               if (IBUS_WAIT_STATES == 0) begin
                  i_commit  = 1'b1;
                  i_state_d = ST_RESP;
               end else begin
                  i_state_d = ST_WAIT;
                  i_cnt_d   = CW'(IBUS_WAIT_STATES);
               end
            end
         end
         ST_WAIT: begin
            if (i_cnt_q == '0) begin
               i_commit  = 1'b1;
               i_state_d = ST_RESP;
            end else begin
               i_cnt_d = i_cnt_q - CW'(1);
            end
         end
         default: i_state_d = ST_IDLE;
      endcase
   end

   // Zero-wait commits straight from the bus; otherwise from the captured request
   assign i_addr_c = (IBUS_WAIT_STATES == 0) ? ibus_address : i_addr_q;
   assign i_hit    = ((i_addr_c >> AW) == 32'd0);
   assign i_idx    = IW'(i_addr_c >> 2);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         i_state_q <= ST_IDLE;
         i_cnt_q   <= '0;
         i_addr_q  <= '0;
         i_rdata_q <= '0;
         i_resp_q  <= 1'b0;
      end else begin
         i_state_q <= i_state_d;
         i_cnt_q   <= i_cnt_d;
         i_resp_q  <= i_commit;
         if (i_accept) i_addr_q <= ibus_address;
         if (i_commit) i_rdata_q <= i_hit ? mem_q[i_idx] : 32'h0;
      end
   end

   assign ibus_rdata     = i_rdata_q;
   assign ibus_rresponse = i_resp_q;

   // ---------------- data port ----------------
   state_e          d_state_q, d_state_d;
   logic [CW-1:0]   d_cnt_q, d_cnt_d;
   logic [31:0]     d_addr_q, d_wdata_q, d_addr_c, d_wdata_c;
   logic [3:0]      d_strb_q, d_strb_c;
   logic            d_write_q, d_write_c;
   logic            d_accept, d_commit, d_hit;
   logic [IW-1:0]   d_idx;
   logic [31:0]     d_rdata_q;
   logic            d_rresp_q, d_wresp_q;

   always_comb begin
      d_state_d = d_state_q;
      d_cnt_d   = d_cnt_q;
      d_accept  = 1'b0;
      d_commit  = 1'b0;
      case (d_state_q)
         ST_IDLE, ST_RESP: begin
            d_state_d = ST_IDLE;
            if ((dbus_rrequest || dbus_wrequest) && reset_n) begin
               d_accept = 1'b1;
               if (DBUS_WAIT_STATES == 0) begin
                  d_commit  = 1'b1;
                  d_state_d = ST_RESP;
               end else begin
                  d_state_d = ST_WAIT;
                  d_cnt_d   = CW'(DBUS_WAIT_STATES);
               end
            end
         end
         ST_WAIT: begin
            if (d_cnt_q == '0) begin
               d_commit  = 1'b1;
               d_state_d = ST_RESP;
            end else begin
               d_cnt_d = d_cnt_q - CW'(1);
            end
         end
         default: d_state_d = ST_IDLE;
      endcase
   end

   // A simultaneous read+write request is treated as a write only
   assign d_addr_c  = (DBUS_WAIT_STATES == 0) ? dbus_address  : d_addr_q;
   assign d_wdata_c = (DBUS_WAIT_STATES == 0) ? dbus_wdata    : d_wdata_q;
   assign d_strb_c  = (DBUS_WAIT_STATES == 0) ? dbus_wstrobe  : d_strb_q;
   assign d_write_c = (DBUS_WAIT_STATES == 0) ? dbus_wrequest : d_write_q;
   assign d_hit     = ((d_addr_c >> AW) == 32'd0);
   assign d_idx     = IW'(d_addr_c >> 2);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         d_state_q <= ST_IDLE;
         d_cnt_q   <= '0;
         d_addr_q  <= '0;
         d_wdata_q <= '0;
         d_strb_q  <= '0;
         d_write_q <= 1'b0;
         d_rdata_q <= '0;
         d_rresp_q <= 1'b0;
         d_wresp_q <= 1'b0;
      end else begin
         d_state_q <= d_state_d;
         d_cnt_q   <= d_cnt_d;
         d_rresp_q <= d_commit && !d_write_c;
         d_wresp_q <= d_commit && d_write_c;
         if (d_accept) begin
            d_addr_q  <= dbus_address;
            d_wdata_q <= dbus_wdata;
            d_strb_q  <= dbus_wstrobe;
            d_write_q <= dbus_wrequest;
         end
         if (d_commit && !d_write_c) d_rdata_q <= d_hit ? mem_q[d_idx] : 32'h0;
      end
   end

   assign dbus_rdata     = d_rdata_q;
   assign dbus_rresponse = d_rresp_q;
   assign dbus_wresponse = d_wresp_q;

   // Array is not reset; fetches on the same edge see the pre-write contents
   always_ff @(posedge clock) begin
      if (d_commit && d_write_c && d_hit) begin
         for (int b = 0; b < 4; b++) begin
            if (d_strb_c[b]) mem_q[d_idx][8*b +: 8] <= d_wdata_c[8*b +: 8];
         end
      end
   end

endmodule
